// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Entry layout, full-word byte-enable mask and a byte-merge helper.
package store_buffer_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef struct packed {
    logic                   valid;
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [31:0]            data;
    logic [3:0]             be;
  } sb_entry_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_d,
    input logic [31:0] new_d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sb_forward.sv
// Youngest-match store-to-load forwarding search.
// Walks entries oldest to youngest so the last match wins.
module sb_forward
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0]  ents,
  input  logic [PW-1:0]          rd_ptr,
  input  logic                   pop,
  input  logic [WORD_ADDR_W-1:0] load_word,
  output logic                   fwd_hit,
  output logic                   fwd_stall,
  output logic [31:0]            fwd_data
);

  logic      found;
  sb_entry_t win;

  // Age-ordered scan; the head is skipped when it leaves this cycle.
  always_comb begin
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (ents[idx].valid &&
          ents[idx].word_addr == load_word &&
          !(pop && k == 0)) begin
        found = 1'b1;
        win   = ents[idx];
      end
    end
  end

  // Full-word match forwards; partial overlap stalls the load.
  always_comb begin
    fwd_hit   = found && (win.be == BE_FULL);
    fwd_stall = found && (win.be != BE_FULL);
    fwd_data  = fwd_hit ? win.data : 32'h0;
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO with in-order drain and load forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge stores into the youngest entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    store_valid,
  input  logic [DATA_WIDTH-1:0]   store_addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [3:0]              store_be,
  output logic                    full,
  input  logic [DATA_WIDTH-1:0]   load_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    fwd_stall,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_ready,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  sb_entry_t [DEPTH-1:0] ents;
  sb_entry_t             head;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         yng;
  logic [PW:0]           cnt;
  logic [WORD_ADDR_W-1:0] st_word;
  logic                  pop;
  logic                  push;
  logic                  merge;
  logic                  unused;

  assign unused  = ^{load_addr[1:0], store_addr[1:0]};
  assign st_word = store_addr[31:2];
  assign head    = ents[rd_ptr];
  assign yng     = wr_ptr - 1'b1;

  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_FULL);
  assign mem_we    = !empty;
  assign mem_addr  = {head.word_addr, 2'b00};
  assign mem_wdata = head.data;
  assign mem_be    = head.be;

  assign pop = mem_we && mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
  assign merge = store_valid && !empty &&
                 ents[yng].valid &&
                 ents[yng].word_addr == st_word &&
                 !(yng == rd_ptr && pop);
`else
  assign merge = 1'b0;
`endif

  assign push = store_valid && !full && !merge;

  // FIFO state: pop at head, allocate or merge at tail, track occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ents   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop) begin
        ents[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        ents[wr_ptr] <= '{valid:     1'b1,
                          word_addr: st_word,
                          data:      store_data,
                          be:        store_be};
        wr_ptr <= wr_ptr + 1'b1;
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (merge) begin
        ents[yng].data <= merge_bytes(ents[yng].data,
                                      store_data, store_be);
        ents[yng].be   <= ents[yng].be | store_be;
      end
`endif
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  sb_forward #(.DEPTH(DEPTH)) u_fwd (
    .ents      (ents),
    .rd_ptr    (rd_ptr),
    .pop       (pop),
    .load_word (load_addr[31:2]),
    .fwd_hit   (fwd_hit),
    .fwd_stall (fwd_stall),
    .fwd_data  (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued
// at issue time and a negedge monitor checks every drained write.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        store_valid;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic        full;
  logic [31:0] load_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t expq[$];
  int  tests;
  int  failed;

`ifdef STORE_BUFFER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .store_valid (store_valid),
    .store_addr  (store_addr),
    .store_data  (store_data),
    .store_be    (store_be),
    .full        (full),
    .load_addr   (load_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fwd_stall   (fwd_stall),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ready   (mem_ready),
    .empty       (empty),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  b);
    wr_t e;
    e.a = {a[31:2], 2'b00};
    e.d = d;
    e.b = b;
    expq.push_back(e);
  endtask

  task automatic put(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0]  b);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_be    = b;
    step();
    store_valid = 1'b0;
  endtask

  // Monitor: every accepted memory write must match the queue head.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      if (expq.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr %h data %h, want none",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
        chk("wr_be", {28'h0, mem_be}, {28'h0, e.b});
      end
    end
  end

  initial begin
    tests       = 0;
    failed      = 0;
    reset       = 1'b1;
    store_valid = 1'b0;
    store_addr  = '0;
    store_data  = '0;
    store_be    = '0;
    load_addr   = '0;
    mem_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // reset / idle
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_full", full, 0);
    chk("rst_hit", fwd_hit, 0);
    chk("rst_stall", fwd_stall, 0);

    // fill to full with memory stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'h100 + 32'(i*4), 32'hA000_0000 + 32'(i), 4'hF);
      put(32'h100 + 32'(i*4), 32'hA000_0000 + 32'(i), 4'hF);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    put(32'h110, 32'hBAD0_0000, 4'hF);
    chk("refuse_count", count, 4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    mem_ready = 1'b0;

    // full-word forwarding; the incoming store is not a source
    store_valid = 1'b1;
    store_addr  = 32'h200;
    store_data  = 32'hDEADBEEF;
    store_be    = 4'hF;
    load_addr   = 32'h200;
    #1;
    chk("no_fwd_from_input", fwd_hit, 0);
    chk("we_before_push", mem_we, 0);
    expect_wr(32'h200, 32'hDEADBEEF, 4'hF);
    step();
    store_valid = 1'b0;
    chk("we_next_cycle", mem_we, 1);
    chk("fwd200_hit", fwd_hit, 1);
    chk("fwd200_data", fwd_data, 32'hDEADBEEF);
    chk("fwd200_stall", fwd_stall, 0);
    load_addr = 32'h203;
    #1;
    chk("fwd203_hit", fwd_hit, 1);
    chk("fwd203_data", fwd_data, 32'hDEADBEEF);
    load_addr = 32'h204;
    #1;
    chk("fwd204_miss", fwd_hit, 0);
    chk("fwd204_data", fwd_data, 0);
    load_addr = 32'h200;
    mem_ready = 1'b1;
    #1;
    chk("fwd_pop_excluded", fwd_hit, 0);
    step();
    chk("fwd200_drained", empty, 1);
    mem_ready = 1'b0;

    // partial overlap: youngest match has a partial byte enable
    if (COAL) begin
      expect_wr(32'h300, 32'h11112211, 4'hF);
    end else begin
      expect_wr(32'h300, 32'h11111111, 4'hF);
      expect_wr(32'h300, 32'h00002200, 4'b0010);
    end
    put(32'h300, 32'h11111111, 4'hF);
    put(32'h301, 32'h00002200, 4'b0010);
    load_addr = 32'h300;
    #1;
    if (COAL) begin
      chk("coal300_hit", fwd_hit, 1);
      chk("coal300_data", fwd_data, 32'h11112211);
      chk("coal300_count", count, 1);
    end else begin
      chk("part300_stall", fwd_stall, 1);
      chk("part300_hit", fwd_hit, 0);
      chk("part300_count", count, 2);
    end
    mem_ready = 1'b1;
    step();
    if (!COAL) step();
    chk("part_drained", empty, 1);
    chk("part_after_hit", fwd_hit, 0);
    chk("part_after_stall", fwd_stall, 0);
    mem_ready = 1'b0;

    // full + drain + store in the same cycle: push refused, then taken
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'h600 + 32'(i*4), 32'h6000_0000 + 32'(i), 4'hF);
      put(32'h600 + 32'(i*4), 32'h6000_0000 + 32'(i), 4'hF);
    end
    chk("fd_full", full, 1);
    mem_ready   = 1'b1;
    store_valid = 1'b1;
    store_addr  = 32'h610;
    store_data  = 32'h6100_0610;
    store_be    = 4'hF;
    step();
    chk("fd_refused_count", count, 3);
    expect_wr(32'h610, 32'h6100_0610, 4'hF);
    step();
    store_valid = 1'b0;
    chk("fd_accept_count", count, 3);
    for (int i = 0; i < 3; i++) step();
    chk("fd_drained", empty, 1);
    mem_ready = 1'b0;

    // same-word byte store after a full word
    if (COAL) begin
      expect_wr(32'h400, 32'hAABBCCEE, 4'hF);
    end else begin
      expect_wr(32'h400, 32'hAABBCCDD, 4'hF);
      expect_wr(32'h400, 32'h000000EE, 4'b0001);
    end
    put(32'h400, 32'hAABBCCDD, 4'hF);
    put(32'h400, 32'h000000EE, 4'b0001);
    chk("c400_count", count, COAL ? 1 : 2);
    mem_ready = 1'b1;
    step();
    if (!COAL) step();
    chk("c400_drained", empty, 1);
    mem_ready = 1'b0;

    // asynchronous reset in the middle of a drain
    put(32'h700, 32'h7000_0000, 4'hF);
    put(32'h704, 32'h7000_0004, 4'hF);
    mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    expq.delete();
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_full", full, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_we", mem_we, 0);
    end
    mem_ready = 1'b0;

    chk("scoreboard_left", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart to the instruction fetch read path.
- Sits between the memory stage and data memory. It accepts committed stores from the pipeline, queues them in a small FIFO, and drains one store per cycle into data memory when memory is ready.
- Provides same-word store-to-load forwarding, so loads behind queued stores see the correct data.
- Raises a stall request when it cannot accept a store or forward a load safely.

Parameters:
- DATA_WIDTH, 32, data and address width.
- DEPTH, 4, number of entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- store_valid  in  1  memory stage presents a store this cycle.
- store_addr  in  DATA_WIDTH  byte address of the store.
- store_data  in  DATA_WIDTH  store data, already lane-aligned.
- store_be  in  4  byte enables.
- full  out  1  count == DEPTH; the hazard unit stalls the memory stage on this.
- load_addr  in  DATA_WIDTH  address of the load in the memory stage.
- fwd_hit  out  1  load fully satisfied from the buffer.
- fwd_data  out  DATA_WIDTH  forwarded word.
- fwd_stall  out  1  partial overlap; the load must wait.
- mem_we  out  1  write request to data memory.
- mem_addr  out  DATA_WIDTH  word-aligned write address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_be  out  4  write byte enables.
- mem_ready  in  1  data memory accepts the write this cycle.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, any time, including mid-drain):
  - rd_ptr = 0, wr_ptr = 0, count = 0, all entry valid bits = 0.
  - Outputs: empty = 1, full = 0, mem_we = 0, fwd_hit = 0, fwd_stall = 0.
  - Data in flight is discarded.
- Entry fields: word address (addr[31:2]), data, be.
  - addr[1:0] is dropped on push; mem_addr = {word_addr, 2'b00}.
- Push:
  - Occurs when store_valid && !full; entry written at wr_ptr, wr_ptr increments, wrapping modulo DEPTH.
  - store_valid while full is not accepted; the upstream stage must hold the store.
  - Push is refused when full even if a drain completes in the same cycle.
  - store_be == 0 is pushed normally; memory ignores it.
- Drain:
  - mem_we = !empty, driven combinationally from the head entry.
  - Pop on the edge where mem_we && mem_ready; rd_ptr increments with wrap.
  - Head outputs remain stable while mem_ready is low.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Latency:
  - A store pushed into an empty buffer appears on mem_we in the next cycle.
  - A store is written to memory no earlier than one cycle after acceptance.
- Forwarding (combinational; store_valid is not itself a forwarding source):
  - Compare load_addr[31:2] against all valid entries, excluding an entry popping this cycle.
  - The youngest matching entry wins.
  - If the winner's be == 4'hF: fwd_hit = 1, fwd_data = that entry's data.
  - If the winner's be != 4'hF: fwd_stall = 1, fwd_hit = 0.
  - No match: both 0, fwd_data = 0.
  - fwd_hit and fwd_stall are never both 1.
- Ordering: memory writes occur strictly in acceptance order.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN
- Defined:
  - A store whose word address equals the youngest valid entry merges into it when all hold: that entry is not the head, or the head is not popping this cycle; count > 0; no other push is pending.
  - Merge: data bytes are overwritten per store_be, and be |= store_be. count and wr_ptr are unchanged.
  - Merging is permitted while full, so full does not block a mergeable store.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Package store_buffer_pkg:
  - sb_entry_t struct {valid, word_addr[29:0], data[31:0], be[3:0]}.
  - BE_FULL = 4'hF.
  - WORD_ADDR_W = 30.
- Sub-module sb_forward: the combinational youngest-match search over the entry array, giving fwd_hit, fwd_stall and fwd_data. The FIFO control stays in store_buffer.

Test Plan:
- Reset then idle: empty = 1, count = 0, mem_we = 0. Assert reset mid-drain with 2 entries queued → outputs return to reset values within the same cycle, and no further mem_we occurs.
- Push 4 stores with mem_ready = 0: full = 1 and count = 4. A fifth store_valid is refused. Raise mem_ready → writes occur in order 0x100, 0x104, 0x108, 0x10C, one per cycle.
- Push sw 0x200 ← 0xDEADBEEF, then load 0x200 → fwd_hit = 1, fwd_data = 0xDEADBEEF. Load 0x203 → same hit (word match).
- Push sw 0x300 ← 0x11111111, then sb 0x301 ← 0x22 (be = 4'b0010). Load 0x300 → fwd_stall = 1 (youngest match is partial). After both drain → no hit, no stall.
- Full buffer with mem_ready = 1 and store_valid = 1: the pop occurs and the push is refused (count = 3 after the edge). The next cycle accepts the push (count = 3 after that edge: one in, one out).
- With STORE_BUFFER_COALESCE_EN: sw 0x400 ← 0xAABBCCDD, then sb 0x400 ← 0xEE (be = 4'b0001) → count stays 1. Memory write is 0xAABBCCEE with be = 4'hF.
